// File: rtl/alu_mc_if.sv
// Handshake and operand/result bundle between the execute-stage issuer and alu_mc.
`timescale 1ns/1ps
interface alu_mc_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned HIGH_LSB = 10
);
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                alu_op;
  logic [WIDTH-1:0]          rdata1_i;
  logic [WIDTH-1:0]          rdata2_i;
  logic [WIDTH-1:0]          imme_i;
  logic                      ALUSrc;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          result_o;
  logic [WIDTH-HIGH_LSB-1:0] result_high_o;
  logic                      zero_o;
  logic                      overflow_o;
  logic                      busy;

  modport master (
    output in_valid, alu_op, rdata1_i, rdata2_i, imme_i, ALUSrc, out_ready,
    input  in_ready, out_valid, result_o, result_high_o, zero_o, overflow_o, busy
  );

  modport slave (
    input  in_valid, alu_op, rdata1_i, rdata2_i, imme_i, ALUSrc, out_ready,
    output in_ready, out_valid, result_o, result_high_o, zero_o, overflow_o, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle arith/logic/compare/shift, iterative shift-add
// multiply, and a valid/ready output register holding the result until taken.
`timescale 1ns/1ps
module alu_mc #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned HIGH_LSB = 10
) (
  input logic     clk,
  input logic     rst_n,
  alu_mc_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, out_valid_q, out_valid_d;

  logic             in_ready_c, accept_c;
  logic [WIDTH-1:0] op_a_c, op_b_c, sum_c, diff_c, alu_res_c, acc_add_c;
  logic [SHW-1:0]   sh_c;
  logic             alu_ovf_c;
  logic             wr_c, wr_ovf_c;
  logic [WIDTH-1:0] wr_res_c;

  assign in_ready_c = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept_c   = bus.in_valid && in_ready_c;

  // Single-cycle datapath on the live operands; only used at the accept edge.
  always_comb begin
    op_a_c    = bus.rdata1_i;
    op_b_c    = bus.ALUSrc ? bus.rdata2_i : bus.imme_i;
    sh_c      = op_b_c[SHW-1:0];
    sum_c     = op_a_c + op_b_c;
    diff_c    = op_a_c - op_b_c;
    alu_res_c = '0;
    alu_ovf_c = 1'b0;
    case (bus.alu_op)
      OP_AND:  alu_res_c = op_a_c & op_b_c;
      OP_OR:   alu_res_c = op_a_c | op_b_c;
      OP_XOR:  alu_res_c = op_a_c ^ op_b_c;
      OP_ADD: begin
        alu_res_c = sum_c;
        alu_ovf_c = (op_a_c[WIDTH-1] == op_b_c[WIDTH-1]) && (sum_c[WIDTH-1] != op_a_c[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_c = diff_c;
        alu_ovf_c = (op_a_c[WIDTH-1] != op_b_c[WIDTH-1]) && (diff_c[WIDTH-1] != op_a_c[WIDTH-1]);
      end
      OP_SLT:  alu_res_c = WIDTH'($signed(op_a_c) < $signed(op_b_c));
      OP_SLTU: alu_res_c = WIDTH'(op_a_c < op_b_c);
      OP_SLL:  alu_res_c = op_a_c << sh_c;
      OP_SRL:  alu_res_c = op_a_c >> sh_c;
      OP_SRA:  alu_res_c = $unsigned($signed(op_a_c) >>> sh_c);
      default: alu_res_c = '0;
    endcase
  end

  assign acc_add_c = b_q[0] ? (acc_q + a_q) : acc_q;

  // Next-state: operation sequencing and output-register update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    wr_c        = 1'b0;
    wr_res_c    = '0;
    wr_ovf_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (bus.alu_op == OP_MUL) begin
            a_d     = op_a_c;
            b_d     = op_b_c;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_MUL;
          end else begin
            wr_c     = 1'b1;
            wr_res_c = alu_res_c;
            wr_ovf_c = alu_ovf_c;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_add_c;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          wr_c     = 1'b1;
          wr_res_c = acc_add_c;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (wr_c) begin
      result_d    = wr_res_c;
      zero_d      = (wr_res_c == '0);
      ovf_d       = wr_ovf_c;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_q;
  assign bus.result_o      = result_q;
  assign bus.result_high_o = result_q[WIDTH-1:HIGH_LSB];
  assign bus.zero_o        = zero_q;
  assign bus.overflow_o    = ovf_q;
  assign bus.busy          = (state_q == S_MUL);
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: issuer pushes expected results, a monitor pops and
// compares each result as it is consumed.
`timescale 1ns/1ps
module tb_alu_mc;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned HIGH_LSB = 10;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t sb_q[$];
  time  last_acc;

  alu_mc_if #(.WIDTH(WIDTH), .HIGH_LSB(HIGH_LSB)) bus ();

  alu_mc #(.WIDTH(WIDTH), .HIGH_LSB(HIGH_LSB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Offer one op, wait (bounded) for acceptance, record expected result.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b2,
                       input logic [31:0] imm, input logic src,
                       input logic [31:0] er, input logic ez, input logic ev);
    int   n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.rdata1_i = a;
    bus.rdata2_i = b2;
    bus.imme_i   = imm;
    bus.ALUSrc   = src;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      last_acc = $time;
      e.res = er; e.z = ez; e.v = ev;
      sb_q.push_back(e);
      #1;
      bus.in_valid = 1'b0;
      bus.rdata1_i = 32'hDEAD_BEEF;
      bus.rdata2_i = 32'h1234_5678;
      bus.imme_i   = 32'hCAFE_F00D;
    end
  endtask

  // Monitor: compare each result on the cycle it is consumed.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", bus.result_o, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        logic [31:0] eh;
        e  = sb_q.pop_front();
        eh = e.res >> HIGH_LSB;
        chk("result", bus.result_o, e.res);
        chk("zero", 32'(bus.zero_o), 32'(e.z));
        chk("overflow", 32'(bus.overflow_o), 32'(e.v));
        chk("result_high", 32'(bus.result_high_o), eh);
      end
    end
  end

  initial begin
    int  n;
    int  bad;
    time t1, t2, t3;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_op   = 4'h0;
    bus.rdata1_i = '0;
    bus.rdata2_i = '0;
    bus.imme_i   = '0;
    bus.ALUSrc   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_result_high", 32'(bus.result_high_o), 32'd0);
    chk("rst_zero", 32'(bus.zero_o), 32'd0);
    chk("rst_overflow", 32'(bus.overflow_o), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops, latency 1
    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    chk("add_latency_valid", 32'(bus.out_valid), 32'd1);
    issue(4'b0110, 32'd5, 32'd9, 32'd5, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0);
    issue(4'b1011, 32'h8000_0000, 32'h24, 32'd0, 1'b1, 32'hF800_0000, 1'b0, 1'b0);
    issue(4'b1010, 32'h8000_0000, 32'h24, 32'd0, 1'b1, 32'h0800_0000, 1'b0, 1'b0);
    issue(4'b1001, 32'd1, 32'd0, 32'd31, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b1, 32'h0000_F000, 1'b0, 1'b0);
    issue(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b1, 32'h0000_FFF0, 1'b0, 1'b0);
    issue(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b1, 32'h0000_0FF0, 1'b0, 1'b0);
    issue(4'b0110, 32'h8000_0000, 32'd1, 32'd0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0);
    issue(4'b1111, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0);

    // Multiply: latency WIDTH, busy throughout, no accepts
    issue(4'b1100, 32'h0001_0003, 32'h0002_0005, 32'd0, 1'b1, 32'h000B_000F, 1'b0, 1'b0);
    n = 0; bad = 0;
    while (n < 100) begin
      if (!bus.out_valid && (!bus.busy || bus.in_ready)) bad++;
      if (bus.out_valid) break;
      @(posedge clk); #1;
      n++;
    end
    chk("mul_latency", 32'(n), 32'd32);
    chk("mul_busy_no_ready", 32'(bad), 32'd0);
    chk("mul_busy_done", 32'(bus.busy), 32'd0);
    issue(4'b1100, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'd1, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;

    // Back-pressure then streaming drain
    bus.out_ready = 1'b0;
    issue(4'b0010, 32'd1, 32'd2, 32'd0, 1'b1, 32'd3, 1'b0, 1'b0);
    fork
      begin
        issue(4'b0010, 32'h10, 32'h20, 32'd0, 1'b1, 32'h30, 1'b0, 1'b0);
        t1 = last_acc;
        issue(4'b0010, 32'h100, 32'h200, 32'd0, 1'b1, 32'h300, 1'b0, 1'b0);
        t2 = last_acc;
        issue(4'b0010, 32'h1000, 32'h2000, 32'd0, 1'b1, 32'h3000, 1'b0, 1'b0);
        t3 = last_acc;
      end
      begin
        bad = 0;
        repeat (5) begin
          @(negedge clk);
          if (bus.result_o !== 32'd3 || !bus.out_valid || bus.in_ready) bad++;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    chk("stream_gap1", 32'(t2 - t1), 32'd10);
    chk("stream_gap2", 32'(t3 - t2), 32'd10);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a multiply
    issue(4'b1100, 32'd7, 32'd6, 32'd0, 1'b1, 32'd42, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    chk("midrst_no_result", 32'(bad), 32'd0);
    @(posedge clk); #1;
    issue(4'b0010, 32'd2, 32'd3, 32'd0, 1'b1, 32'd5, 1'b0, 1'b0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
